mem_slave_sram: RTL

MEM_SLAVE_SRAM -- requirements
Module: mem_slave_sram

---
 rtl/mem_slave_pkg.sv | 21 ++
 rtl/mem_slave_resp_pipe.sv | 32 +++
 rtl/mem_slave_sram.sv | 110 +++++++++++
 3 files changed

// File: rtl/mem_slave_pkg.sv
// Shared types and constants for the mem_slave_sram block.
// The LFSR constants are only consumed when MEM_SLAVE_STALL_EN is defined.
package mem_slave_pkg;

  // One slot of the response pipeline
  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [31:0] rdata;
  } resp_entry_t;

  // Stall LFSR seed and feedback taps (x^16 + x^14 + x^13 + x^11 + 1, right-shifting form)
  localparam logic [15:0] LFSR_SEED     = 16'hACE1;
  localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;

  // Next state of the Fibonacci LFSR: feedback enters at the MSB
  function automatic logic [15:0] lfsr_next(input logic [15:0] state);
    return {^(state & LFSR_TAP_MASK), state[15:1]};
  endfunction

endpackage

// File: rtl/mem_slave_resp_pipe.sv
// Fixed-latency response shift register: an entry written at the grant edge
// appears on o_entry exactly LATENCY cycles later.
module mem_slave_resp_pipe
  import mem_slave_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  resp_entry_t i_entry,
  output resp_entry_t o_entry
);

  resp_entry_t r_stage [LATENCY];

  // Shift responses toward the output; reset drops everything in flight
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_entry;
      for (int i = 1; i < LATENCY; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_entry = r_stage[LATENCY-1];

endmodule

// File: rtl/mem_slave_sram.sv
// Word-addressed SRAM slave with byte-enabled writes and fixed-latency,
// in-order responses for both reads and writes.
// Optional feature: define MEM_SLAVE_STALL_EN to add pseudo-random grant stalls.
module mem_slave_sram
  import mem_slave_pkg::*;
#(
  parameter int ADDRESS_SIZE    = 64,
  parameter int NUM_WORDS       = 1024,
  parameter int LATENCY         = 1,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [ADDRESS_SIZE-1:0] address_i,
  input  logic [31:0]             data_wdata_i,
  input  logic                    data_req_i,
  input  logic                    data_we_i,
  input  logic [3:0]              data_be_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  output logic [31:0]             data_rdata_o
);

  localparam int IDX_W = $clog2(NUM_WORDS);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [31:0]      r_mem [NUM_WORDS];
  logic [CNT_W-1:0] r_count;

  logic [IDX_W-1:0] w_idx;
  logic             w_permit;
  logic             w_gnt;
  logic             w_rvalid;
  resp_entry_t      w_req_entry;
  resp_entry_t      w_resp_entry;
  logic             w_unused_addr;

  // Only the word-index bits select a location; the rest are don't-care
  assign w_idx         = address_i[IDX_W+1:2];
  assign w_unused_addr = ^{address_i[ADDRESS_SIZE-1:IDX_W+2], address_i[1:0]};

`ifdef MEM_SLAVE_STALL_EN
  logic [15:0] r_lfsr;

  // Free-running stall generator; roughly one cycle in four withholds the grant
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  assign w_permit = (r_lfsr[1:0] != 2'b00);
`else
  assign w_permit = 1'b1;
`endif

  // Grant is held low throughout reset so a waiting master sees no acceptance
  assign w_gnt      = rst_ni & data_req_i & (r_count < CNT_W'(MAX_OUTSTANDING)) & w_permit;
  assign data_gnt_o = w_gnt;

  // Build the response entry at the grant edge; reads sample the store before any later write
  always_comb begin
    w_req_entry          = '0;
    w_req_entry.valid    = w_gnt;
    w_req_entry.is_write = w_gnt & data_we_i;
    if (w_gnt && !data_we_i) begin
      w_req_entry.rdata = r_mem[w_idx];
    end
  end

  // Byte-enabled store update; contents survive reset on purpose
  always_ff @(posedge clk_i) begin
    if (w_gnt && data_we_i) begin
      for (int k = 0; k < 4; k++) begin
        if (data_be_i[k]) begin
          r_mem[w_idx][8*k +: 8] <= data_wdata_i[8*k +: 8];
        end
      end
    end
  end

  mem_slave_resp_pipe #(
    .LATENCY (LATENCY)
  ) u_resp_pipe (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_entry (w_req_entry),
    .o_entry (w_resp_entry)
  );

  assign w_rvalid      = rst_ni & w_resp_entry.valid;
  assign data_rvalid_o = w_rvalid;
  assign data_rdata_o  = (w_rvalid && !w_resp_entry.is_write) ? w_resp_entry.rdata : 32'h0;

  // Outstanding count: a grant and a response in the same cycle cancel out
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_count <= '0;
    end else begin
      case ({w_gnt, w_rvalid})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
